// File: rtl/p5_cpu_pkg.sv
// p5_cpu shared definitions: state encoding, opcode/op constants, shift
// codes, instruction field positions and a field-extraction helper.
package p5_cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WRITE, S_WRITE_IMM, S_HALT
  } state_t;

  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op under OPC_MOV
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  // op under OPC_ALU; doubles as the ALU function select
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam int OPC_HI = 15, OPC_LO = 13;
  localparam int OP_HI  = 12, OP_LO  = 11;
  localparam int RN_HI  = 10, RN_LO  = 8;
  localparam int RD_HI  = 7,  RD_LO  = 5;
  localparam int SH_HI  = 4,  SH_LO  = 3;
  localparam int RM_HI  = 2,  RM_LO  = 0;
  localparam int IMM_HI = 7,  IMM_LO = 0;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic [7:0] imm8;
  } instr_t;

  function automatic instr_t fields(input logic [15:0] ir);
    instr_t f;
    f.opcode = ir[OPC_HI:OPC_LO];
    f.op     = ir[OP_HI:OP_LO];
    f.rn     = ir[RN_HI:RN_LO];
    f.rd     = ir[RD_HI:RD_LO];
    f.sh     = ir[SH_HI:SH_LO];
    f.rm     = ir[RM_HI:RM_LO];
    f.imm8   = ir[IMM_HI:IMM_LO];
    return f;
  endfunction

endpackage

// File: rtl/p5_alu.sv
// p5_alu: combinational barrel shift of B, ALU and status-flag computation.
module p5_alu import p5_cpu_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ain,
  input  logic [DATA_W-1:0] bin,
  input  logic [1:0]        sh,
  input  logic [1:0]        aluop,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              v,
  output logic              z
);

  logic [DATA_W-1:0] bsh;

  // single-position shift of the Rm operand
  always_comb begin
    bsh = bin;
    case (sh)
      SH_LSL:  bsh = {bin[DATA_W-2:0], 1'b0};
      SH_LSR:  bsh = {1'b0, bin[DATA_W-1:1]};
      SH_ASR:  bsh = {bin[DATA_W-1], bin[DATA_W-1:1]};
      default: bsh = bin;
    endcase
  end

  // function select; add wraps modulo 2^DATA_W
  always_comb begin
    result = '0;
    case (aluop)
      OP_ADD:  result = ain + bsh;
      OP_CMP:  result = ain - bsh;
      OP_AND:  result = ain & bsh;
      default: result = ~bsh;
    endcase
  end

  // v is the subtraction overflow: operand signs differ and the result
  // sign differs from A. Only consumed when the op is CMP.
  assign n = result[DATA_W-1];
  assign z = (result == '0);
  assign v = (ain[DATA_W-1] ^ bsh[DATA_W-1]) & (result[DATA_W-1] ^ ain[DATA_W-1]);

endmodule

// File: rtl/p5_cpu.sv
// p5_cpu: multi-cycle simple-RISC core (FSM, IR, register file, A/B/C,
// flags). Optional HALT instruction enabled by defining CPU_HALT_EN.
module p5_cpu import p5_cpu_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [15:0]       in,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              w,
  output logic              ill
`ifdef CPU_HALT_EN
  ,
  output logic              halted
`endif
);

  state_t                     state, nstate;
  logic [15:0]                ir;
  logic [DATA_W-1:0]          ra, rb, rc;
  logic [7:0][DATA_W-1:0]     regs;
  instr_t                     f;
  logic                       is_mov, is_cmp;
  logic [DATA_W-1:0]          ain, alu_res, sximm8;
  logic [1:0]                 aluop;
  logic                       alu_n, alu_v, alu_z;

  assign f      = fields(ir);
  assign is_mov = (f.opcode == OPC_MOV);
  assign is_cmp = (f.opcode == OPC_ALU) && (f.op == OP_CMP);
  assign sximm8 = {{(DATA_W-8){f.imm8[7]}}, f.imm8};

  // MOV reg reuses the adder with A forced to zero
  assign ain   = is_mov ? '0 : ra;
  assign aluop = is_mov ? OP_ADD : f.op;

  p5_alu #(.DATA_W(DATA_W)) u_alu (
    .ain(ain), .bin(rb), .sh(f.sh), .aluop(aluop),
    .result(alu_res), .n(alu_n), .v(alu_v), .z(alu_z)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_WAIT;
    else        state <= nstate;
  end

  // next state and illegal-instruction strobe
  always_comb begin
    nstate = state;
    ill    = 1'b0;
    case (state)
      S_WAIT:   if (s) nstate = S_DECODE;
      S_DECODE: begin
        nstate = S_WAIT;
        if (is_mov && f.op == OP_MOVI)                      nstate = S_WRITE_IMM;
        else if ((is_mov && f.op == OP_MOVR) ||
                 (f.opcode == OPC_ALU && f.op == OP_MVN))   nstate = S_GETB;
        else if (f.opcode == OPC_ALU)                       nstate = S_GETA;
`ifdef CPU_HALT_EN
        else if (f.opcode == OPC_HALT)                      nstate = S_HALT;
`endif
        else                                                ill    = 1'b1;
      end
      S_GETA:      nstate = S_GETB;
      S_GETB:      nstate = S_EXEC;
      S_EXEC:      nstate = is_cmp ? S_WAIT : S_WRITE;
      S_WRITE:     nstate = S_WAIT;
      S_WRITE_IMM: nstate = S_WAIT;
`ifdef CPU_HALT_EN
      S_HALT:      nstate = S_HALT;
`endif
      default:     nstate = S_WAIT;
    endcase
  end

  // datapath: IR, operand latches, C, flags and register writeback
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir   <= '0;
      ra   <= '0;
      rb   <= '0;
      rc   <= '0;
      regs <= '0;
      N    <= 1'b0;
      V    <= 1'b0;
      Z    <= 1'b0;
    end else begin
      if (load && state == S_WAIT) ir <= in;
      case (state)
        S_GETA: ra <= regs[f.rn];
        S_GETB: rb <= regs[f.rm];
        S_EXEC: begin
          if (is_cmp) begin
            N <= alu_n;
            V <= alu_v;
            Z <= alu_z;
          end else begin
            rc <= alu_res;
          end
        end
        S_WRITE:     regs[f.rd] <= rc;
        S_WRITE_IMM: regs[f.rn] <= sximm8;
        default: ;
      endcase
    end
  end

  assign out = rc;
  assign w   = (state == S_WAIT);
`ifdef CPU_HALT_EN
  assign halted = (state == S_HALT);
`endif

endmodule

// File: tb/tb_p5_cpu.sv
// tb_p5_cpu: directed test of p5_cpu with a reference model feeding a
// scoreboard queue of expected out/flags/w-low/ill counts per instruction.
module tb_p5_cpu;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, s, load;
  logic [15:0]   in;
  logic [DW-1:0] out;
  logic          N, V, Z, w, ill;
`ifdef CPU_HALT_EN
  logic          halted;
`endif

  always #5 clk = ~clk;

  p5_cpu #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .out(out), .N(N), .V(V), .Z(Z), .w(w), .ill(ill)
`ifdef CPU_HALT_EN
    , .halted(halted)
`endif
  );

  typedef struct {
    logic [15:0] out;
    logic        n, v, z;
    int          cyc;
    int          ills;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_r[8];
  logic [15:0] m_c;
  logic        m_n, m_v, m_z;
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic logic [15:0] enc(input logic [2:0] opc, input logic [1:0] op,
                                      input logic [2:0] rn, input logic [2:0] rd,
                                      input logic [1:0] shc, input logic [2:0] rm);
    return {opc, op, rn, rd, shc, rm};
  endfunction

  function automatic logic [15:0] movi(input logic [2:0] rn, input logic [7:0] imm);
    return {3'b110, 2'b10, rn, imm};
  endfunction

  function automatic logic [15:0] msh(input logic [15:0] x, input logic [1:0] c);
    case (c)
      2'd1:    return {x[14:0], 1'b0};
      2'd2:    return {1'b0, x[15:1]};
      2'd3:    return {x[15], x[15:1]};
      default: return x;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_c = '0; m_n = 1'b0; m_v = 1'b0; m_z = 1'b0;
  endtask

  // reference behaviour of one instruction; pushes what the DUT must show
  task automatic model(input logic [15:0] i);
    exp_t        e;
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, shc;
    logic [15:0] b, res;
    int          diff;
    opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; shc = i[4:3]; rm = i[2:0];
    e.cyc = 1; e.ills = 1;
    b = msh(m_r[rm], shc);
    if (opc == 3'b110 && op == 2'b10) begin
      m_r[rn] = {{8{i[7]}}, i[7:0]}; e.cyc = 2; e.ills = 0;
    end else if (opc == 3'b110 && op == 2'b00) begin
      m_c = b; m_r[rd] = m_c; e.cyc = 4; e.ills = 0;
    end else if (opc == 3'b101) begin
      e.ills = 0;
      case (op)
        2'b00: begin m_c = m_r[rn] + b; m_r[rd] = m_c; e.cyc = 5; end
        2'b01: begin
          res  = m_r[rn] - b;
          diff = int'($signed(m_r[rn])) - int'($signed(b));
          m_n  = res[15];
          m_z  = (res == 16'h0);
          m_v  = (diff > 32767) || (diff < -32768);
          e.cyc = 4;
        end
        2'b10: begin m_c = m_r[rn] & b; m_r[rd] = m_c; e.cyc = 5; end
        default: begin m_c = ~b; m_r[rd] = m_c; e.cyc = 4; end
      endcase
    end
    e.out = m_c; e.n = m_n; e.v = m_v; e.z = m_z;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // issue one instruction (load and start together), time w low, then
  // compare against the oldest scoreboard entry
  task automatic run(input logic [15:0] i, input string tag);
    exp_t e;
    int   cyc, ills;
    model(i);
    @(negedge clk); in = i; load = 1'b1; s = 1'b1;
    @(posedge clk); #1; load = 1'b0; s = 1'b0;
    cyc = 0; ills = 0;
    while (w !== 1'b1 && cyc < 40) begin
      cyc++;
      if (ill === 1'b1) ills++;
      @(posedge clk); #1;
    end
    e = sb.pop_front();
    check({tag, ".wlow"}, cyc, e.cyc);
    check({tag, ".ill"}, ills, e.ills);
    check({tag, ".out"}, out, e.out);
    check({tag, ".N"}, N, e.n);
    check({tag, ".V"}, V, e.v);
    check({tag, ".Z"}, Z, e.z);
  endtask

  initial begin
    reset = 1'b0; s = 1'b0; load = 1'b0; in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.w", w, 1'b1);
    check("rst.out", out, 16'h0);
    check("rst.NVZ", {N, V, Z}, 3'b000);
    check("rst.ill", ill, 1'b0);
    reset = 1'b1;

    // MOV imm then MOV reg
    run(movi(3'd0, 8'hFD), "movi_r0");
    run(enc(3'b110, 2'b00, 3'd0, 3'd1, 2'b00, 3'd0), "movr_r1");
    check("movr_r1.const", out, 16'hFFFD);

    // ADD with LSL on Rm; readback of R2 through MOV
    run(movi(3'd0, 8'h05), "movi_r0b");
    run(movi(3'd1, 8'h03), "movi_r1");
    run(16'hA049, "add_lsl");
    check("add_lsl.const", out, 16'h000B);
    run(enc(3'b110, 2'b00, 3'd0, 3'd3, 2'b00, 3'd2), "rd_r2");

    // shifter codes, MVN and AND
    run(movi(3'd5, 8'h80), "movi_r5");
    run(enc(3'b101, 2'b11, 3'd0, 3'd6, 2'b11, 3'd5), "mvn_asr");
    check("mvn_asr.const", out, 16'h003F);
    run(enc(3'b110, 2'b00, 3'd0, 3'd6, 2'b10, 3'd5), "mov_lsr");
    run(enc(3'b101, 2'b10, 3'd5, 3'd7, 2'b00, 3'd1), "and_none");
    run(enc(3'b101, 2'b10, 3'd5, 3'd7, 2'b01, 3'd5), "and_lsl");

    // CMP equal
    run(movi(3'd0, 8'h07), "movi_r0c");
    run(movi(3'd1, 8'h07), "movi_r1c");
    run(16'hA801, "cmp_eq");
    check("cmp_eq.const", {N, V, Z}, 3'b001);

    // CMP 8000 - 0001 overflows; build 8000 as ~(FFFF >> 1)
    run(movi(3'd0, 8'hFF), "movi_ff");
    run(enc(3'b110, 2'b00, 3'd0, 3'd2, 2'b10, 3'd0), "mov_7fff");
    run(enc(3'b101, 2'b11, 3'd0, 3'd0, 2'b00, 3'd2), "mvn_8000");
    run(movi(3'd1, 8'h01), "movi_r1d");
    run(16'hA801, "cmp_ovf");
    check("cmp_ovf.const", {N, V, Z}, 3'b010);
    run(enc(3'b101, 2'b01, 3'd1, 3'd0, 2'b00, 3'd0), "cmp_neg");
    run(enc(3'b110, 2'b00, 3'd0, 3'd4, 2'b00, 3'd0), "rd_r0");

    // illegal encodings leave state alone
    run(16'h0000, "ill_0000");
    run(16'hC800, "ill_c800");
    run(16'h6000, "ill_6000");
`ifndef CPU_HALT_EN
    run(16'hE000, "ill_e000");
`endif

    // reset during GETB of an ADD to R2
    @(negedge clk); in = enc(3'b101, 2'b00, 3'd0, 3'd2, 2'b00, 3'd1); load = 1'b1; s = 1'b1;
    @(posedge clk); #1; load = 1'b0; s = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst.busy", w, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    check("midrst.w", w, 1'b1);
    check("midrst.out", out, 16'h0);
    check("midrst.NVZ", {N, V, Z}, 3'b000);
    run(enc(3'b110, 2'b00, 3'd0, 3'd3, 2'b00, 3'd2), "midrst_r2");

`ifdef CPU_HALT_EN
    @(negedge clk); in = 16'hE000; load = 1'b1; s = 1'b1;
    @(posedge clk); #1; load = 1'b0; s = 1'b0;
    @(posedge clk); #1;
    check("halt.halted", halted, 1'b1);
    check("halt.w", w, 1'b0);
    repeat (3) begin
      @(negedge clk); in = movi(3'd0, 8'h11); load = 1'b1; s = 1'b1;
    end
    @(posedge clk); #1; load = 1'b0; s = 1'b0;
    check("halt.stay", {halted, w}, 2'b10);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("halt.rst", {halted, w}, 2'b01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
